// File: rtl/muldiv_operand_stage.sv
// Operand conditioning register stage in front of an iterative multiply/divide unit.
// It captures rs1/rs2, folds signed operands to magnitudes and flags the special cases that can skip the iterative unit.
module muldiv_operand_stage #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2:0]      out_op_o,
  output logic [XLEN-1:0] out_a_o,
  output logic [XLEN-1:0] out_b_o,
  output logic            neg_result_o,
  output logic [5:0]      status_o,
  output logic            early_o,
  output logic [XLEN-1:0] early_result_o
);

  if (XLEN < 8) begin : g_xlen_check
    $error("muldiv_operand_stage: XLEN must be at least 8");
  end

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE_VAL  = {{(XLEN-1){1'b0}}, 1'b1};

  logic            is_div;
  logic            sa;
  logic            sb;
  logic            a_neg;
  logic            b_neg;
  logic            a_zero;
  logic            a_one;
  logic            a_ones;
  logic            b_zero;
  logic            b_one;
  logic            b_ones;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            neg_nxt;
  logic [5:0]      status_nxt;
  logic            early_nxt;
  logic [XLEN-1:0] early_res_nxt;
  logic            in_ready_core;
  logic            xfer_in;

  // op_i[2] selects divide/remainder; op_i[1] distinguishes REM from DIV.
  assign is_div = op_i[2];
  assign sa     = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
  assign sb     = is_div ? ~op_i[0] : ~op_i[1];

  assign a_neg = sa & a_i[XLEN-1];
  assign b_neg = sb & b_i[XLEN-1];

  // The magnitude of MIN wraps back to the same bit pattern, which reads as 2^(XLEN-1) unsigned.
  assign a_mag = a_neg ? (~a_i) + ONE_VAL : a_i;
  assign b_mag = b_neg ? (~b_i) + ONE_VAL : b_i;

  assign a_zero = (a_i == '0);
  assign a_one  = (a_i == ONE_VAL);
  assign a_ones = (a_i == ALL_ONES);
  assign b_zero = (b_i == '0);
  assign b_one  = (b_i == ONE_VAL);
  assign b_ones = (b_i == ALL_ONES);

  assign status_nxt = {b_ones & sb, b_one, b_zero, a_ones & sa, a_one, a_zero};

  always_comb begin
    neg_nxt = 1'b0;
    if (!is_div) begin
      neg_nxt = a_neg ^ b_neg;
    end else if (sa) begin
      if (op_i[1]) begin
        neg_nxt = a_i[XLEN-1];
      end else begin
        neg_nxt = b_zero ? 1'b0 : (a_i[XLEN-1] ^ b_i[XLEN-1]);
      end
    end
  end

  always_comb begin
    early_nxt     = 1'b0;
    early_res_nxt = '0;
    if (EARLY_OUT) begin
      if (is_div && b_zero) begin
        early_nxt     = 1'b1;
        early_res_nxt = op_i[1] ? a_i : ALL_ONES;
      end else if (is_div && sa && (a_i == MIN_VAL) && b_ones) begin
        early_nxt     = 1'b1;
        early_res_nxt = op_i[1] ? '0 : MIN_VAL;
      end else if (!is_div && (a_zero || b_zero)) begin
        early_nxt     = 1'b1;
        early_res_nxt = '0;
      end
    end
  end

  assign in_ready_core = ~flush_i & (~out_valid_o | out_ready_i);
  assign in_ready_o    = in_ready_core | ~reset_i;
  assign xfer_in       = in_valid_i & in_ready_core;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_valid_o    <= 1'b0;
      out_op_o       <= '0;
      out_a_o        <= '0;
      out_b_o        <= '0;
      neg_result_o   <= 1'b0;
      status_o       <= '0;
      early_o        <= 1'b0;
      early_result_o <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (xfer_in) begin
      out_valid_o    <= 1'b1;
      out_op_o       <= op_i;
      out_a_o        <= a_mag;
      out_b_o        <= b_mag;
      neg_result_o   <= neg_nxt;
      status_o       <= status_nxt;
      early_o        <= early_nxt;
      early_result_o <= early_res_nxt;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_operand_stage.sv
// Self-checking bench for muldiv_operand_stage: directed spec cases plus randomized traffic vs. an arithmetic reference model.
module tb_muldiv_operand_stage;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        neg;
    logic [5:0]  st;
    logic        early;
    logic [31:0] er;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [2:0]  out_op_o;
  logic [31:0] out_a_o;
  logic [31:0] out_b_o;
  logic        neg_result_o;
  logic [5:0]  status_o;
  logic        early_o;
  logic [31:0] early_result_o;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   m_valid = 1'b0;
  exp_t m_exp;

  muldiv_operand_stage #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_op_o(out_op_o),
    .out_a_o(out_a_o), .out_b_o(out_b_o), .neg_result_o(neg_result_o),
    .status_o(status_o), .early_o(early_o), .early_result_o(early_result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference built from the instruction semantics on plain integers.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    bit          is_div, is_rem, sa, sb;
    longint      va, vb, ma, mb;
    logic [63:0] ta, tb;
    is_div = (op >= 3'd4);
    is_rem = (op == 3'd6) || (op == 3'd7);
    sa = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sb = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    va = sa ? longint'($signed(a)) : longint'(a);
    vb = sb ? longint'($signed(b)) : longint'(b);
    ma = (va < 0) ? -va : va;
    mb = (vb < 0) ? -vb : vb;
    ta = ma;
    tb = mb;
    e.op = op;
    e.a  = ta[31:0];
    e.b  = tb[31:0];
    if (!is_div)          e.neg = (va < 0) != (vb < 0);
    else if (op == 3'd4)  e.neg = (b != 0) && ((va < 0) != (vb < 0));
    else if (op == 3'd6)  e.neg = (va < 0);
    else                  e.neg = 1'b0;
    e.st = {sb && (vb == -1), b == 32'd1, b == 32'd0, sa && (va == -1), a == 32'd1, a == 32'd0};
    e.early = 1'b0;
    e.er    = 32'd0;
    if (is_div && b == 0) begin
      e.early = 1'b1;
      e.er    = is_rem ? a : 32'hFFFF_FFFF;
    end else if ((op == 3'd4 || op == 3'd6) && va == -64'sd2147483648 && vb == -1) begin
      e.early = 1'b1;
      e.er    = (op == 3'd4) ? 32'h8000_0000 : 32'd0;
    end else if (!is_div && (a == 0 || b == 0)) begin
      e.early = 1'b1;
    end
    return e;
  endfunction

  task automatic check_outputs();
    bit exp_rdy;
    exp_rdy = !reset_i || (!flush_i && (!m_valid || out_ready_i));
    chk("in_ready", {63'd0, in_ready_o}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, out_valid_o}, {63'd0, m_valid});
    if (m_valid) begin
      chk("out_op", {61'd0, out_op_o}, {61'd0, m_exp.op});
      chk("out_a", {32'd0, out_a_o}, {32'd0, m_exp.a});
      chk("out_b", {32'd0, out_b_o}, {32'd0, m_exp.b});
      chk("neg_result", {63'd0, neg_result_o}, {63'd0, m_exp.neg});
      chk("status", {58'd0, status_o}, {58'd0, m_exp.st});
      chk("early", {63'd0, early_o}, {63'd0, m_exp.early});
      chk("early_result", {32'd0, early_result_o}, {32'd0, m_exp.er});
    end
  endtask

  task automatic model_edge();
    if (!reset_i)                                  m_valid = 1'b0;
    else if (flush_i)                              m_valid = 1'b0;
    else if (in_valid_i && (!m_valid || out_ready_i)) begin
      m_valid = 1'b1;
      m_exp   = ref_model(op_i, a_i, b_i);
    end else if (out_ready_i)                      m_valid = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  // Presents one request with the sink ready; on return the entry is held at the output.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; a_i = a; b_i = b; in_valid_i = 1'b1; out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #2;
    chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_ready", {63'd0, in_ready_o}, 64'd1);
    chk("rst_status", {58'd0, status_o}, 64'd0);
    chk("rst_early", {32'd0, early_result_o}, 64'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    tick();

    send(3'd4, 32'hFFFF_FFEC, 32'd3);
    chk("div_a", {32'd0, out_a_o}, 64'd20);
    chk("div_b", {32'd0, out_b_o}, 64'd3);
    chk("div_neg", {63'd0, neg_result_o}, 64'd1);
    chk("div_early", {63'd0, early_o}, 64'd0);
    chk("div_status", {58'd0, status_o}, 64'd0);

    send(3'd5, 32'h1234, 32'd0);
    chk("divu0_early", {63'd0, early_o}, 64'd1);
    chk("divu0_res", {32'd0, early_result_o}, 64'hFFFF_FFFF);
    chk("divu0_b0", {63'd0, status_o[3]}, 64'd1);
    send(3'd7, 32'h1234, 32'd0);
    chk("remu0_res", {32'd0, early_result_o}, 64'h1234);

    send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_early", {63'd0, early_o}, 64'd1);
    chk("ovf_res", {32'd0, early_result_o}, 64'h8000_0000);
    chk("ovf_bm1", {63'd0, status_o[5]}, 64'd1);
    send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_rem_early", {63'd0, early_o}, 64'd1);
    chk("ovf_rem_res", {32'd0, early_result_o}, 64'd0);
    send(3'd5, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divu_big_early", {63'd0, early_o}, 64'd0);
    chk("divu_big_bm1", {63'd0, status_o[5]}, 64'd0);

    send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulhsu_a", {32'd0, out_a_o}, 64'd1);
    chk("mulhsu_b", {32'd0, out_b_o}, 64'hFFFF_FFFF);
    chk("mulhsu_neg", {63'd0, neg_result_o}, 64'd1);
    chk("mulhsu_am1", {63'd0, status_o[2]}, 64'd1);
    chk("mulhsu_bm1", {63'd0, status_o[5]}, 64'd0);

    send(3'd1, 32'd0, 32'd9);
    chk("mul_zero_early", {63'd0, early_o}, 64'd1);
    out_ready_i = 1'b1;
    tick();

    // Backpressure then flush with a request pending.
    send(3'd0, 32'hFFFF_FFF9, 32'd5);
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; op_i = 3'd3; a_i = 32'd77; b_i = 32'd88;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_a", {32'd0, out_a_o}, 64'd7);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_valid", {63'd0, out_valid_o}, 64'd0);
    tick();

    // Back-to-back stream, order checked by operand value.
    out_ready_i = 1'b1; in_valid_i = 1'b1; op_i = 3'd5; b_i = 32'd7;
    for (int i = 0; i < 8; i++) begin
      a_i = 32'(i + 1);
      tick();
      chk("b2b_valid", {63'd0, out_valid_o}, 64'd1);
      chk("b2b_order", {32'd0, out_a_o}, 64'(i + 1));
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    tick();
    reset_i = 1'b0;
    m_valid = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("async_rst_a", {32'd0, out_a_o}, 64'd0);
    chk("async_rst_ready", {63'd0, in_ready_o}, 64'd1);
    tick();
    reset_i = 1'b1;
    out_ready_i = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 600; i++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 15) == 0);
      op_i        = 3'($urandom_range(0, 7));
      a_i         = pick();
      b_i         = pick();
      tick();
    end
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
